// File: rtl/pu_requant_mp.sv
// Row requantiser: int accumulators are scaled, rounded, shifted, offset and saturated to
// REQUANT_WD, or top-bit truncated in bypass mode. 3-stage pipeline with per-stage valids.
module pu_requant_mp #(
  parameter int PE_OUTPUT_WD = 24,
  parameter int PE_COL_NUM   = 32,
  parameter int OC_NUM       = 4,
  parameter int SCALE_WD     = 16,
  parameter int SHIFT_WD     = 5,
  parameter int REQUANT_WD   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      vld_i,
  output logic                                      rdy_o,
  input  logic [OC_NUM*PE_COL_NUM*PE_OUTPUT_WD-1:0] data_i,
  input  logic [OC_NUM*SCALE_WD-1:0]                scale_i,
  input  logic [OC_NUM*SHIFT_WD-1:0]                shift_i,
  input  logic [OC_NUM*REQUANT_WD-1:0]              zp_i,
  input  logic [1:0]                                mode_i,
  input  logic                                      uns_i,
  output logic                                      vld_o,
  input  logic                                      rdy_i,
  output logic [OC_NUM*PE_COL_NUM*REQUANT_WD-1:0]   data_o
);

  localparam int LANES = OC_NUM * PE_COL_NUM;
  localparam int PW    = PE_OUTPUT_WD + SCALE_WD + 1;
  localparam int AW    = PW + 1;
  localparam int QW    = AW + 1;

  localparam logic signed [QW-1:0] SMAX = QW'(2 ** (REQUANT_WD - 1) - 1);
  localparam logic signed [QW-1:0] SMIN = QW'(-(2 ** (REQUANT_WD - 1)));
  localparam logic signed [QW-1:0] UMAX = QW'(2 ** REQUANT_WD - 1);

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd2;

  logic       v1, v2, v3;
  logic       en1, en2, en3;
  logic [1:0] mode1, mode2;
  logic       uns1, uns2;

  // Each stage loads when empty or when its successor is taking its contents.
  assign en3   = ~v3 | rdy_i;
  assign en2   = ~v2 | en3;
  assign en1   = ~v1 | en2;
  assign rdy_o = en1;
  assign vld_o = v3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= vld_i;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (en1) begin
      mode1 <= mode_i;
      uns1  <= uns_i;
    end
    if (en2) begin
      mode2 <= mode1;
      uns2  <= uns1;
    end
  end

  for (genvar oc = 0; oc < OC_NUM; oc++) begin : g_oc
    localparam int OCR = OC_NUM - 1 - oc;

    logic        [SCALE_WD-1:0]   scl;
    logic        [SHIFT_WD-1:0]   shift1;
    logic signed [REQUANT_WD-1:0] zp1;
    logic signed [AW-1:0]         rnd;

    assign scl = scale_i[OCR*SCALE_WD +: SCALE_WD];

    always_ff @(posedge clk) begin
      if (en1) begin
        shift1 <= shift_i[OCR*SHIFT_WD +: SHIFT_WD];
        zp1    <= zp_i[OCR*REQUANT_WD +: REQUANT_WD];
      end
    end

    // Half-LSB bias gives round-half-toward-+inf with the arithmetic shift.
    assign rnd = (shift1 == '0) ? '0 : (AW'(1) << (shift1 - 1'b1));

    for (genvar e = 0; e < PE_COL_NUM; e++) begin : g_el
      localparam int JR = LANES - 1 - (oc * PE_COL_NUM + e);

      logic signed [PE_OUTPUT_WD-1:0] acc;
      logic signed [PW-1:0]           acc_x, scl_x, p1;
      logic        [REQUANT_WD-1:0]   byp1, byp2, y_n, y3;
      logic signed [AW-1:0]           r, rl;
      logic signed [QW-1:0]           q, q2;

      assign acc   = data_i[JR*PE_OUTPUT_WD +: PE_OUTPUT_WD];
      assign acc_x = PW'(acc);
      assign scl_x = PW'(scl);

      always_ff @(posedge clk) begin
        if (en1) begin
          p1   <= acc_x * scl_x;
          byp1 <= acc[PE_OUTPUT_WD-1 -: REQUANT_WD];
        end
      end

      assign r = (AW'(p1) + rnd) >>> shift1;

      always_comb begin
        rl = r;
        if (mode1 == MODE_RELU && r[AW-1]) rl = '0;
      end

      assign q = QW'(rl) + QW'(zp1);

      always_ff @(posedge clk) begin
        if (en2) begin
          q2   <= q;
          byp2 <= byp1;
        end
      end

      always_comb begin
        y_n = byp2;
        if (mode2 != MODE_BYPASS) begin
          if (uns2) begin
            if (q2[QW-1])       y_n = '0;
            else if (q2 > UMAX) y_n = '1;
            else                y_n = q2[REQUANT_WD-1:0];
          end else begin
            if (q2 < SMIN)      y_n = {1'b1, {(REQUANT_WD-1){1'b0}}};
            else if (q2 > SMAX) y_n = {1'b0, {(REQUANT_WD-1){1'b1}}};
            else                y_n = q2[REQUANT_WD-1:0];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (en3) y3 <= y_n;
      end

      assign data_o[JR*REQUANT_WD +: REQUANT_WD] = y3;
    end
  end

endmodule

// File: tb/tb_pu_requant_mp.sv
// Directed bench for pu_requant_mp: hand-computed vectors, backpressure, per-beat params, reset.
module tb_pu_requant_mp;

  localparam int DW    = 24;
  localparam int COLS  = 32;
  localparam int OCN   = 4;
  localparam int SW    = 16;
  localparam int HW    = 5;
  localparam int RW    = 8;
  localparam int LANES = OCN * COLS;

  logic                  clk;
  logic                  rst;
  logic                  vld_i;
  logic                  rdy_o;
  logic [LANES*DW-1:0]   data_i;
  logic [OCN*SW-1:0]     scale_i;
  logic [OCN*HW-1:0]     shift_i;
  logic [OCN*RW-1:0]     zp_i;
  logic [1:0]            mode_i;
  logic                  uns_i;
  logic                  vld_o;
  logic                  rdy_i;
  logic [LANES*RW-1:0]   data_o;

  logic signed [DW-1:0]  lx [LANES];
  logic [SW-1:0]         sc [OCN];
  logic [HW-1:0]         sh [OCN];
  logic [RW-1:0]         zpv [OCN];
  logic [RW-1:0]         ey [LANES];

  int checks;
  int errors;

  pu_requant_mp dut (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (vld_i),
    .rdy_o   (rdy_o),
    .data_i  (data_i),
    .scale_i (scale_i),
    .shift_i (shift_i),
    .zp_i    (zp_i),
    .mode_i  (mode_i),
    .uns_i   (uns_i),
    .vld_o   (vld_o),
    .rdy_i   (rdy_i),
    .data_o  (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int j = 0; j < LANES; j++) data_i[(LANES-1-j)*DW +: DW] = lx[j];
    for (int k = 0; k < OCN; k++) begin
      scale_i[(OCN-1-k)*SW +: SW] = sc[k];
      shift_i[(OCN-1-k)*HW +: HW] = sh[k];
      zp_i[(OCN-1-k)*RW +: RW]    = zpv[k];
    end
  endtask

  task automatic set_x(input int x);
    for (int j = 0; j < LANES; j++) lx[j] = DW'(x);
  endtask

  task automatic set_p(input int s, input int h, input int z);
    for (int k = 0; k < OCN; k++) begin
      sc[k]  = SW'(s);
      sh[k]  = HW'(h);
      zpv[k] = RW'(z);
    end
  endtask

  task automatic set_ey(input int y);
    for (int j = 0; j < LANES; j++) ey[j] = RW'(y);
  endtask

  task automatic check_lanes(input string tag);
    int bad;
    logic [RW-1:0] o;
    bad = 0;
    for (int j = LANES - 1; j >= 0; j--)
      if (data_o[(LANES-1-j)*RW +: RW] !== ey[j]) bad = j;
    o = data_o[(LANES-1-bad)*RW +: RW];
    chk($sformatf("%s[lane %0d]", tag, bad), o, ey[bad]);
  endtask

  // Sends one beat with rdy_i high, checks 3-edge latency and the row, then drains it.
  task automatic one_beat(input string tag, input logic [1:0] m, input logic u);
    int lat;
    mode_i = m;
    uns_i  = u;
    rdy_i  = 1'b1;
    apply();
    vld_i  = 1'b1;
    #1;
    chk({tag, "_rdy"}, rdy_o, 1'b1);
    tick();
    vld_i = 1'b0;
    lat = 1;
    while (!vld_o && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    check_lanes(tag);
    tick();
  endtask

  initial begin
    int sent, recv, acc, first_c, last_c;
    logic stall_prev;
    logic [LANES*RW-1:0] held;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    vld_i  = 1'b0;
    rdy_i  = 1'b1;
    mode_i = 2'd1;
    uns_i  = 1'b0;
    set_x(0);
    set_p(1, 0, 0);
    apply();
    tick();
    tick();
    tick();
    chk("reset_vld_o", vld_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_reset_rdy_o", rdy_o, 1'b1);
    chk("post_reset_vld_o", vld_o, 1'b0);

    // Rounding: 101*16384/32768 = 50.5 -> 51, +10
    set_p(16384, 15, 10);
    set_x(101);  set_ey(61);  one_beat("round_pos_half", 2'd1, 1'b0);
    set_x(-101); set_ey(-40); one_beat("round_neg_half", 2'd1, 1'b0);
    set_x(100);  set_ey(60);  one_beat("round_exact", 2'd1, 1'b0);

    // Saturation
    set_p(32767, 15, 0);
    set_x(1000);  set_ey(127);  one_beat("sat_hi_signed", 2'd1, 1'b0);
    set_x(1000);  set_ey(255);  one_beat("sat_hi_unsigned", 2'd1, 1'b1);
    set_x(-1000); set_ey(-128); one_beat("sat_lo_signed", 2'd1, 1'b0);
    set_x(-1000); set_ey(0);    one_beat("sat_lo_unsigned", 2'd1, 1'b1);

    // ReLU, reserved mode behaving as plain requant, bypass truncation
    set_p(1, 0, 5);
    set_x(-20); set_ey(5);   one_beat("relu_clamp", 2'd2, 1'b0);
    set_x(-20); set_ey(-15); one_beat("mode3_no_relu", 2'd3, 1'b0);
    set_p(1, 3, 5);
    set_x(24'hABCDEF); set_ey(8'hAB); one_beat("bypass_trunc", 2'd0, 1'b1);

    // Lane independence: x = element-16, zp = 10*oc-15
    for (int k = 0; k < OCN; k++) begin
      sc[k] = 16'd1; sh[k] = 5'd0; zpv[k] = RW'(10 * k - 15);
    end
    for (int k = 0; k < OCN; k++)
      for (int e = 0; e < COLS; e++) begin
        lx[k*COLS+e] = DW'(e - 16);
        ey[k*COLS+e] = RW'(e - 16 + 10 * k - 15);
      end
    one_beat("lane_map", 2'd1, 1'b0);

    // Backpressure: 8 beats, random rdy_i
    set_p(1, 0, 0);
    mode_i = 2'd1;
    uns_i  = 1'b0;
    sent = 0;
    recv = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 300 && recv < 8; c++) begin
      vld_i = (sent < 8);
      set_x(sent * 10 + 1);
      apply();
      rdy_i = 1'($urandom_range(0, 1));
      #1;
      if (stall_prev) begin
        chk("bp_stall_vld", vld_o, 1'b1);
        chk("bp_stall_stable", data_o === held, 1'b1);
      end
      if (vld_o && rdy_i) begin
        set_ey(recv * 10 + 1);
        check_lanes($sformatf("bp_out%0d", recv));
        recv++;
      end
      stall_prev = vld_o && !rdy_i;
      held = data_o;
      if (vld_i && rdy_o) sent++;
      tick();
    end
    vld_i = 1'b0;
    chk("bp_count", recv, 8);
    rdy_i = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_no_extra", vld_o, 1'b0);

    // rdy_i held low: exactly three beats fit
    rdy_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_x(40 + acc);
      apply();
      vld_i = 1'b1;
      #1;
      if (!rdy_o) break;
      acc++;
      tick();
    end
    vld_i = 1'b0;
    chk("hold_accepted", acc, 3);
    chk("hold_rdy_o", rdy_o, 1'b0);
    rdy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_drain_vld%0d", k), vld_o, 1'b1);
      set_ey(40 + k);
      check_lanes($sformatf("hold_drain%0d", k));
      tick();
    end
    chk("hold_drained", vld_o, 1'b0);

    // Per-beat shift alternating 0/4 with x=33: 33, 2, 33, 2
    set_x(33);
    sent = 0;
    recv = 0;
    first_c = 0;
    last_c = 0;
    for (int c = 0; c < 30 && recv < 4; c++) begin
      if (sent < 4) begin
        set_p(1, (sent % 2 == 1) ? 4 : 0, 0);
        apply();
        vld_i = 1'b1;
      end else begin
        vld_i = 1'b0;
      end
      #1;
      if (vld_o) begin
        set_ey((recv % 2 == 1) ? 2 : 33);
        check_lanes($sformatf("perbeat%0d", recv));
        if (recv == 0) first_c = c;
        last_c = c;
        recv++;
      end
      if (vld_i && rdy_o) sent++;
      tick();
    end
    vld_i = 1'b0;
    chk("perbeat_count", recv, 4);
    chk("perbeat_throughput", last_c - first_c, 3);

    // Reset with a full pipe
    set_p(1, 0, 0);
    rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_x(k + 1);
      apply();
      vld_i = 1'b1;
      #1;
      chk($sformatf("rmf_accept%0d", k), rdy_o, 1'b1);
      tick();
    end
    vld_i = 1'b0;
    chk("rmf_full", vld_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmf_vld_cleared", vld_o, 1'b0);
    chk("rmf_rdy_o", rdy_o, 1'b1);
    set_x(77);
    set_ey(77);
    one_beat("rmf_first_after", 2'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_requant_mp.md
PU_REQUANT_MP -- requirements
Module: pu_requant_mp

Interface
REQ-001 SHALL have parameters: PE_OUTPUT_WD=24 (accumulator width, signed); PE_COL_NUM=32 (elements per row); OC_NUM=4 (output channels per beat); SCALE_WD=16 (unsigned multiplier); SHIFT_WD=5 (right-shift amount); REQUANT_WD=8 (output width).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- vld_i  in  1  input beat valid.
- rdy_o  out  1  input beat accepted when vld_i&rdy_o.
- data_i  in  OC_NUM*PE_COL_NUM*PE_OUTPUT_WD  signed accumulators; OC k at the MSB end; element 0 of each OC at its MSB end.
- scale_i  in  OC_NUM*SCALE_WD  per-OC multiplier, same OC ordering.
- shift_i  in  OC_NUM*SHIFT_WD  per-OC right shift.
- zp_i  in  OC_NUM*REQUANT_WD  per-OC zero point, two's complement.
- mode_i  in  2  0=bypass, 1=requant, 2=requant+ReLU, 3=reserved (treated as 1).
- uns_i  in  1  1=unsigned output range, 0=signed.
- vld_o  out  1  output beat valid.
- rdy_i  in  1  downstream ready.
- data_o  out  OC_NUM*PE_COL_NUM*REQUANT_WD  requantised row, same ordering as data_i.

Function
REQ-004 SHALL be a 3-stage pipeline: S1 multiply, S2 round/shift/ReLU/zero-point add, S3 saturate and register output.
REQ-005 SHALL have a latency of exactly 3 cycles from an accepted beat to vld_o when rdy_i stays high; throughput 1 beat/cycle.
REQ-006 SHALL give each stage s its own valid flag v_s, and stage s SHALL load when ~v_s | rdy_(s+1) (bubble collapse); rdy_o = ~v1 | rdy_2; the output stage's ready is rdy_i.
REQ-007 SHALL capture scale_i, shift_i, zp_i, mode_i and uns_i with the data at S1 and carry them down the pipe, so parameters may change on every beat.
REQ-008 SHALL, in S1, form p = data × $signed({1'b0,scale}), width PE_OUTPUT_WD+SCALE_WD+1, signed.
REQ-009 SHALL, in S2, compute r = (p + (1<<(shift-1))) >>> shift when shift>0 (round half toward +inf), and r = p when shift=0.
REQ-010 SHALL, in S2, clamp r to 0 if r<0 when mode=2, then form q = r + sign-extended zp.
REQ-011 SHALL, in S3 and with uns=0, saturate q to [-(2^(REQUANT_WD-1)), 2^(REQUANT_WD-1)-1]; with uns=1 it SHALL saturate to [0, 2^REQUANT_WD-1].
REQ-012 SHALL, in mode 0, output the top REQUANT_WD bits of each accumulator unchanged (legacy truncation), ignoring scale, shift, zp and uns.
REQ-013 SHALL hold data_o and vld_o stable while vld_o=1 and rdy_i=0.
REQ-014 SHALL use no intermediate width that overflows for any legal input: the S2 adder is one bit wider than p, and zp is added at full width.
REQ-015 SHALL treat OCs and elements independently, with no cross-lane dependency.

Reset
REQ-016 SHALL, while rst=1 at a clock edge, clear all stage valids (vld_o=0) and leave data registers unspecified (no reset needed).
REQ-017 SHALL drive rdy_o=1 in the cycle after reset deasserts.
REQ-018 SHALL, on reset mid-operation, discard all in-flight beats, with no output for them after reset.

Verification
REQ-019 SHALL pass a rounding test: mode=1, uns=0, scale=16384, shift=15, zp=10, x=101 -> 61; x=-101 -> -40; x=100 -> 60.
REQ-020 SHALL pass a saturation test: mode=1, scale=32767, shift=15, zp=0, x=1000 -> 127 (uns=0), 255 (uns=1); x=-1000 -> -128 (uns=0), 0 (uns=1).
REQ-021 SHALL pass a ReLU/bypass test: mode=2, scale=1, shift=0, zp=5, x=-20 -> 5; mode=0, x=24'hABCDEF -> 8'hAB.
REQ-022 SHALL pass a backpressure test: 8 back-to-back beats with rdy_i toggled randomly -> all 8 outputs in order, none dropped or duplicated, data_o stable during stalls; with rdy_i held low, rdy_o falls after 3 accepted beats.
REQ-023 SHALL pass a per-beat parameter test: alternate shift=0/shift=4 each beat with x=33, scale=1 -> outputs 33, 2, 33, 2, ...
REQ-024 SHALL pass a reset-mid-flight test: assert rst for 1 cycle with 3 beats in flight -> vld_o=0 next cycle, and the first later output is the first beat sent after reset.
